// File: rtl/mw_lsu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : mw_lsu_writeback
// Purpose  : Memory/writeback stage. Consumes the registered MW-stage bundle,
//            performs byte/half/word loads and stores against a multi-cycle
//            data memory (req/ready handshake with timeout abort), drives the
//            register-file write port and stalls the pipeline front while a
//            memory access is outstanding.
// Ports    : clk, rst (async, active-high)
//            pc_mw/inst_mw/alu_mw/wd_mw/wb_sel_mw/reg_wr_mw/wr_en_mw/rd_en_mw
//                                          - MW-stage bundle
//            dmem_req/we/addr/wdata/be     - memory request (held while BUSY)
//            dmem_ready/dmem_rdata         - memory completion and read word
//            rf_we/rf_waddr/rf_wdata       - register-file write port
//            stall, misalign_exc, bus_err  - pipeline control / exceptions
// Revision : 1.0 - initial release
// ============================================================================
module mw_lsu_writeback #(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_mw,
  input  logic [31:0]     inst_mw,
  input  logic [XLEN-1:0] alu_mw,
  input  logic [XLEN-1:0] wd_mw,
  input  logic [1:0]      wb_sel_mw,
  input  logic            reg_wr_mw,
  input  logic            wr_en_mw,
  input  logic            rd_en_mw,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            stall,
  output logic            misalign_exc,
  output logic            bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_wr_q, reg_wr_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic            abort_q, abort_d;

  // Decode of the incoming MW-stage instruction.
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic            mem_op;
  logic            misaligned;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] rdata_shift;
  logic [XLEN-1:0] load_data;
  logic            unused_ok;

  assign f3     = inst_mw[14:12];
  assign rd     = inst_mw[11:7];
  assign mem_op = wr_en_mw | rd_en_mw;

  // Sizes 10 and the undefined 11 are both treated as word accesses.
  assign misaligned = ((f3[1:0] == 2'b01) & alu_mw[0]) |
                      (f3[1] & (alu_mw[1:0] != 2'b00));

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wd_mw;
    case (f3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_mw[1:0];
        wdata_new = {4{wd_mw[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << alu_mw[1:0];
        wdata_new = {2{wd_mw[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wd_mw;
      end
    endcase
  end

  // Extract the addressed byte/half from the captured read word.
  assign rdata_shift = rdata_q >> {off_q, 3'b000};

  always_comb begin
    load_data = rdata_q;
    case (f3_q[1:0])
      2'b00:   load_data = {{(XLEN-8){~f3_q[2] & rdata_shift[7]}},  rdata_shift[7:0]};
      2'b01:   load_data = {{(XLEN-16){~f3_q[2] & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_data = rdata_q;
    endcase
  end

  // Bits of the instruction word this stage has no use for.
  assign unused_ok = ^{inst_mw[31:15], inst_mw[6:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      reg_wr_q <= 1'b0;
      wb_sel_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      reg_wr_q <= reg_wr_d;
      wb_sel_q <= wb_sel_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    be_d         = be_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    reg_wr_d     = reg_wr_q;
    wb_sel_d     = wb_sel_q;
    abort_d      = abort_q;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = rd;
    rf_wdata     = '0;
    stall        = 1'b0;
    misalign_exc = 1'b0;
    bus_err      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            misalign_exc = 1'b1;
          end else begin
            stall    = 1'b1;
            addr_d   = {alu_mw[XLEN-1:2], 2'b00};
            wdata_d  = wdata_new;
            be_d     = be_new;
            we_d     = wr_en_mw;        // store wins over a simultaneous load
            f3_d     = f3;
            off_d    = alu_mw[1:0];
            rd_d     = rd;
            reg_wr_d = reg_wr_mw;
            wb_sel_d = wb_sel_mw;
            abort_d  = 1'b0;
            cnt_d    = '0;
            state_d  = S_BUSY;
          end
        end else begin
          rf_we = reg_wr_mw & (rd != 5'd0);
          case (wb_sel_mw)
            2'b00:   rf_wdata = alu_mw;
            2'b10:   rf_wdata = pc_mw + XLEN'(4);
            default: rf_wdata = '0;
          endcase
        end
      end

      S_BUSY: begin
        dmem_req = 1'b1;
        dmem_we  = we_q;
        stall    = 1'b1;
        if (dmem_ready) begin
          rdata_d = dmem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          bus_err = 1'b1;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        rf_waddr = rd_q;
        rf_we    = ~we_q & reg_wr_q & (rd_q != 5'd0) & ~abort_q;
        rf_wdata = (wb_sel_q == 2'b11) ? '0 : load_data;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule
`default_nettype wire

// File: doc/mw_lsu_writeback.md
Name: mw_lsu_writeback

Overview:
- Consumer end of the execute-to-memory/writeback pipeline register.
- Takes the registered MW-stage bundle (pc, inst, alu result, store data, wb_sel, reg_wr, wr_en, rd_en) and performs loads and stores against a multi-cycle data memory over a req/ready handshake.
- Drives the register-file write port.
- Stalls the front of the pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles in BUSY without dmem_ready before the access is aborted with bus_err.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- pc_mw  in  32  PC of the MW-stage instruction.
- inst_mw  in  32  instruction. funct3=[14:12], rd=[11:7].
- alu_mw  in  32  ALU result, also the effective address.
- wd_mw  in  32  store data (rs2).
- wb_sel_mw  in  2  writeback select: 00 alu, 01 load, 10 pc+4, 11 reserved (writes 0).
- reg_wr_mw  in  1  register write enable.
- wr_en_mw  in  1  store request.
- rd_en_mw  in  1  load request.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1=store.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-shifted store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  request accepted and completed this cycle. rdata valid with it.
- dmem_rdata  in  32  read word.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  destination register.
- rf_wdata  out  32  writeback data.
- stall  out  1  hold PC, IF/ID and MW registers.
- misalign_exc  out  1  misaligned access detected.
- bus_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Async reset:
  - state=IDLE, timeout counter=0, all captured registers=0.
  - dmem_req, dmem_we, rf_we, stall, misalign_exc, bus_err all 0.
  - dmem_addr, dmem_wdata, dmem_be all 0.
  - Reset mid-access abandons the request immediately. No rf write.
- mem_op = wr_en_mw | rd_en_mw. When both are set, the store wins and the load is ignored.
- Alignment:
  - funct3[1:0]: 00 byte, 01 half, 10 word.
  - Misaligned when half and addr[0]=1, or word and addr[1:0]!=0.
- IDLE, non-memory op:
  - rf_we = reg_wr_mw & (rd!=0).
  - rf_wdata muxed combinationally from alu_mw or pc_mw+4.
  - stall=0.
- IDLE, mem_op and misaligned:
  - misalign_exc=1 (combinational).
  - No request, no rf write, stall=0, stay IDLE.
- IDLE, mem_op and aligned:
  - stall=1 combinationally.
  - Capture addr, be, shifted wdata, we, funct3, addr[1:0], rd, reg_wr and wb_sel.
  - Next state BUSY. rf_we=0.
- Byte enables: byte -> 4'b0001<<addr[1:0]. Half -> 4'b0011<<addr[1:0]. Word -> 4'b1111.
- Store data: wd replicated into the lanes (byte x4, half x2).
- BUSY:
  - dmem_req=1 and stall=1. Request outputs come from the captured registers and hold stable until dmem_ready.
  - On dmem_ready: capture dmem_rdata, go to DONE.
  - Else the counter increments. If counter==TIMEOUT-1 and no ready: bus_err=1 that cycle, drop the request, go to DONE with the writeback-suppress flag set.
- DONE:
  - stall=0 and dmem_req=0. The MW-stage inputs are ignored.
  - Load with reg_wr and rd!=0 and no abort: rf_we=1, rf_waddr=captured rd.
  - Load data: select the byte/half at the captured offset. funct3[2]=0 sign-extends, funct3[2]=1 zero-extends (LBU/LHU).
  - Next state IDLE, counter cleared.
- Latency:
  - Load with dmem_ready on the first BUSY cycle: 3 cycles IDLE->BUSY->DONE, write in DONE.
  - Each extra wait cycle adds 1.
- rd==0: rf_we is never asserted.

Test Plan:
- ADD path: wb_sel=00, reg_wr=1, rd=5, alu=0x1234 in IDLE -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, stall=0.
- LW at 0x100, memory ready after 2 wait cycles, rdata=0xDEADBEEF:
  - stall=1 for 4 cycles (IDLE+3 BUSY).
  - dmem_addr=0x100, be=1111.
  - DONE: rf_wdata=0xDEADBEEF.
- LB at 0x103, rdata=0x80FFFFFF -> rf_wdata=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at 0x102, wd=0x0000ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, rf_we=0 in DONE.
- LW at 0x101 -> misalign_exc=1, dmem_req never asserted, stall=0. Both wr_en and rd_en set -> store performed.
- No dmem_ready for TIMEOUT cycles -> bus_err pulse, no rf write, back in IDLE. Assert rst in BUSY -> dmem_req and stall drop asynchronously, state IDLE.
